pio_output_pulse_ts: RTL and testbench
======================================

Name: pio_output_pulse_ts

Overview:
Parametrised successor of the single-register Avalon-MM output PIO used on the HPS lightweight bridge. It adds atomic set/clear registers and a per-bit auto-clearing pulse mode with programmable length. It also has a free-running cycle counter, captured on every output update, so software can timestamp ARM-to-FPGA writes. It sits on an Avalon-MM slave with read latency 1 and drives fabric logic directly from out_port.

Parameters:
DATA_WIDTH, 32, width of out_port; legal range 1..32
PULSE_CNT_W, 16, width of the PULSE_LEN register and the pulse down-counter
RESET_VALUE, 0, value of DATA after reset (DATA_WIDTH LSBs used)

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data; only the LSBs each register needs are used
readdata  out  32  registered read data; valid 1 cycle after address is presented; zero-extended
out_port  out  DATA_WIDTH  current DATA register
pulse_active  out  1  high while the pulse counter is running
pulse_done  out  1  one-cycle strobe in the cycle the pulse bits clear

Behaviour:
- Reset: clk and reset fixed as above (one clock; reset synchronous, active-high). While reset is high: DATA=RESET_VALUE, MODE=0, PULSE_LEN=1, TS_NOW=0, TS_LAST=0, overflow=0, counter idle, readdata=0, pulse_active=0, pulse_done=0. Reset asserted mid-pulse aborts the pulse with no pulse_done.
- A write is chipselect & ~write_n. It takes effect at the clock edge; out_port shows the new value in the following cycle.
- Register map:
  - 0 DATA: read/write.
  - 1 MODE: read/write; per-bit pulse enable.
  - 2 PULSE_LEN: read/write, PULSE_CNT_W bits; a written value of 0 is stored as 1.
  - 3 TS_LAST: read-only.
  - 4 OUTSET: write sets bits, DATA |= wd; reads 0.
  - 5 OUTCLEAR: write clears bits, DATA &= ~wd; reads 0.
  - 6 TS_NOW: read gives the counter; any write clears it to 0.
  - 7 STATUS: bit0=pulse_active, bit1=overflow (sticky); writing 1 to bit1 clears it.
- TS_NOW: 32-bit counter, increments every cycle and wraps 0xFFFFFFFF->0. A wrap sets overflow. A write to TS_NOW in the same cycle as a wrap gives 0 with no overflow.
- TS_LAST: on any write to DATA, OUTSET or OUTCLEAR, loads the TS_NOW value of that write cycle, even if DATA is unchanged.
- Pulse start: a write to DATA or OUTSET whose resulting DATA&MODE is nonzero loads the counter and raises pulse_active from the next cycle. A new trigger while active reloads the counter (retrigger).
- Pulse length: pulse-mode bits are high on out_port for exactly PULSE_LEN cycles. At expiry DATA &= ~MODE, pulse_active falls, and pulse_done=1 for one cycle, all visible in the same cycle.
- Non-pulse bits are never touched by expiry.
- Expiry in the same cycle as a write:
  - OUTCLEAR: both masks apply.
  - DATA or OUTSET: the write wins; reload if it is a trigger, else the pulse ends with pulse_done.
- Writing MODE or PULSE_LEN while active does not reload. Expiry clears using MODE as it is at expiry time.
- An OUTCLEAR that zeroes all pulse bits while active stops the counter with no pulse_done.
- Reads: readdata registered from address each cycle; unused upper bits are 0; no side effects on read.

Test Plan:
- Reset with RESET_VALUE=0xA5 -> out_port=0xA5, readdata of MODE=0, PULSE_LEN reads 1, STATUS=0.
- DATA=0x0000_00F0, OUTSET 0x0F, OUTCLEAR 0x30 -> out_port=0xCF; each write updates TS_LAST, and successive TS_LAST values differ by the cycle gap.
- MODE=0x1, PULSE_LEN=5, OUTSET 0x1 -> out_port[0] high exactly 5 cycles, pulse_done one cycle at fall, bit1 unaffected if set.
- PULSE_LEN=10, trigger, retrigger at cycle 6 -> bit high 16 cycles total, single pulse_done. Also PULSE_LEN written 0 -> reads 1, pulse lasts 1 cycle.
- Force TS_NOW near wrap (write clear, run 2^32 in a reduced-width build or via hierarchical force to 0xFFFFFFFE) -> wraps to 0, STATUS.bit1=1, write 0x2 to STATUS -> bit1=0.
- Reset asserted at cycle 3 of an 8-cycle pulse -> out_port=RESET_VALUE next cycle, pulse_active=0, no pulse_done. Also OUTCLEAR in the expiry cycle -> both masks applied.

Source files
------------

// File: rtl/pio_output_pulse_ts.sv
// Avalon-MM output PIO with atomic set/clear, per-bit auto-clearing pulse mode,
// and a free-running cycle counter captured on every output update.
module pio_output_pulse_ts #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          PULSE_CNT_W = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          TS_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_active,
    output logic                  pulse_done
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_MODE     = 3'd1;
    localparam logic [2:0] A_PLEN     = 3'd2;
    localparam logic [2:0] A_TS_LAST  = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_TS_NOW   = 3'd6;
    localparam logic [2:0] A_STATUS   = 3'd7;

    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  r_mode;
    logic [PULSE_CNT_W-1:0] r_plen;
    logic [PULSE_CNT_W-1:0] r_cnt;
    logic                   r_active;
    logic                   r_done;
    logic [TS_W-1:0]        r_ts_now;
    logic [TS_W-1:0]        r_ts_last;
    logic                   r_ovf;
    logic [31:0]            r_rdata;

    logic                   w_wr;
    logic [DATA_WIDTH-1:0]  w_wd;
    logic                   w_expire;
    logic [DATA_WIDTH-1:0]  w_data_next;
    logic                   w_trig;
    logic                   w_stop;
    logic                   w_ts_clr;
    logic                   w_wrap;
    logic                   w_out_wr;
    logic [31:0]            w_rd;

    always_comb begin
        w_wr     = chipselect & ~write_n;
        w_wd     = writedata[DATA_WIDTH-1:0];
        w_expire = r_active && (r_cnt == PULSE_CNT_W'(1));
        w_ts_clr = w_wr && (address == A_TS_NOW);
        w_wrap   = &r_ts_now;
        w_out_wr = w_wr && ((address == A_DATA) || (address == A_OUTSET) ||
                            (address == A_OUTCLEAR));

        // DATA and OUTSET writes override expiry; OUTCLEAR stacks on top of it.
        w_data_next = r_data;
        if (w_wr && (address == A_DATA)) begin
            w_data_next = w_wd;
        end else if (w_wr && (address == A_OUTSET)) begin
            w_data_next = r_data | w_wd;
        end else begin
            if (w_expire) begin
                w_data_next = w_data_next & ~r_mode;
            end
            if (w_wr && (address == A_OUTCLEAR)) begin
                w_data_next = w_data_next & ~w_wd;
            end
        end

        w_trig = w_wr && ((address == A_DATA) || (address == A_OUTSET)) &&
                 (|(w_data_next & r_mode));
        w_stop = r_active && w_wr && (address == A_OUTCLEAR) &&
                 !(|(w_data_next & r_mode));

        w_rd = '0;
        case (address)
            A_DATA:    w_rd[DATA_WIDTH-1:0]  = r_data;
            A_MODE:    w_rd[DATA_WIDTH-1:0]  = r_mode;
            A_PLEN:    w_rd[PULSE_CNT_W-1:0] = r_plen;
            A_TS_LAST: w_rd[TS_W-1:0]        = r_ts_last;
            A_TS_NOW:  w_rd[TS_W-1:0]        = r_ts_now;
            A_STATUS:  w_rd[1:0]             = {r_ovf, r_active};
            default:   w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= RESET_VALUE[DATA_WIDTH-1:0];
            r_mode    <= '0;
            r_plen    <= PULSE_CNT_W'(1);
            r_cnt     <= '0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_ts_now  <= '0;
            r_ts_last <= '0;
            r_ovf     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_data  <= w_data_next;
            r_rdata <= w_rd;

            if (w_wr && (address == A_MODE)) begin
                r_mode <= w_wd;
            end
            if (w_wr && (address == A_PLEN)) begin
                r_plen <= (writedata[PULSE_CNT_W-1:0] == '0) ? PULSE_CNT_W'(1)
                                                             : writedata[PULSE_CNT_W-1:0];
            end

            r_ts_now <= w_ts_clr ? '0 : r_ts_now + TS_W'(1);
            if (w_out_wr) begin
                r_ts_last <= r_ts_now;
            end
            // A wrap coinciding with a counter clear is not an overflow.
            if (w_wrap && !w_ts_clr) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (address == A_STATUS) && writedata[1]) begin
                r_ovf <= 1'b0;
            end

            r_done <= 1'b0;
            if (w_trig) begin
                r_active <= 1'b1;
                r_cnt    <= r_plen;
            end else if (w_expire) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_cnt    <= '0;
            end else if (w_stop) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else if (r_active) begin
                r_cnt <= r_cnt - PULSE_CNT_W'(1);
            end
        end
    end

    assign readdata     = r_rdata;
    assign out_port     = r_data;
    assign pulse_active = r_active;
    assign pulse_done   = r_done;

endmodule

// File: tb/tb_pio_output_pulse_ts.sv
// Bench for pio_output_pulse_ts: directed steps then random traffic, each cycle
// checked against a deadline-based reference model of the register/pulse rules.
module tb_pio_output_pulse_ts;

    localparam int          DW     = 8;
    localparam int          PCW    = 6;
    localparam int          TW     = 10;
    localparam logic [31:0] RV     = 32'hA5;
    localparam int          TS_MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          pulse_active;
    logic          pulse_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: the pulse is tracked by the absolute cycle in which
    // its clearing becomes visible, not by a down-counter.
    logic [DW-1:0] m_data = RV[DW-1:0];
    logic [DW-1:0] m_mode = '0;
    int            m_plen = 1;
    int            m_ts = 0;
    int            m_tslast = 0;
    int            m_deadline = 0;
    bit            m_ovf = 1'b0;
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    logic [31:0]   m_rd = '0;
    int            t = 0;

    pio_output_pulse_ts #(
        .DATA_WIDTH (DW),
        .PULSE_CNT_W(PCW),
        .RESET_VALUE(RV),
        .TS_W       (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_port    (out_port),
        .pulse_active(pulse_active),
        .pulse_done  (pulse_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h t=%0d", tag, obs, exp, t);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v[DW-1:0] = m_data;
            3'd1: v[DW-1:0] = m_mode;
            3'd2: v = 32'(m_plen);
            3'd3: v = 32'(m_tslast);
            3'd6: v = 32'(m_ts);
            3'd7: v = {30'd0, m_ovf, m_active};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_update(input logic rst, input logic [2:0] a, input logic cs,
                                input logic wn, input logic [31:0] wd);
        logic [DW-1:0] wdd;
        logic [DW-1:0] d;
        bit wr, expiring, trig;
        int ts_next;
        m_rd = rst ? 32'd0 : m_read(a);
        if (rst) begin
            m_data = RV[DW-1:0]; m_mode = '0; m_plen = 1; m_ts = 0; m_tslast = 0;
            m_ovf = 0; m_active = 0; m_done = 0;
        end else begin
            wr  = cs && !wn;
            wdd = wd[DW-1:0];
            expiring = m_active && (t + 1 == m_deadline);
            d = m_data;
            if (wr && a == 3'd0) d = wdd;
            else if (wr && a == 3'd4) d = m_data | wdd;
            else begin
                if (expiring) d = d & ~m_mode;
                if (wr && a == 3'd5) d = d & ~wdd;
            end
            trig = wr && (a == 3'd0 || a == 3'd4) && ((d & m_mode) != '0);
            m_done = 0;
            if (trig) begin
                m_active = 1; m_deadline = t + 1 + m_plen;
            end else if (expiring) begin
                m_active = 0; m_done = 1;
            end else if (m_active && wr && a == 3'd5 && (d & m_mode) == '0) begin
                m_active = 0;
            end
            if (wr && (a == 3'd0 || a == 3'd4 || a == 3'd5)) m_tslast = m_ts;
            if (wr && a == 3'd6) ts_next = 0;
            else ts_next = (m_ts == TS_MAX) ? 0 : m_ts + 1;
            if (m_ts == TS_MAX && !(wr && a == 3'd6)) m_ovf = 1;
            else if (wr && a == 3'd7 && wd[1]) m_ovf = 0;
            m_ts = ts_next;
            m_data = d;
            if (wr && a == 3'd1) m_mode = wdd;
            if (wr && a == 3'd2) m_plen = (wd[PCW-1:0] == '0) ? 1 : int'(wd[PCW-1:0]);
        end
        t++;
    endtask

    task automatic step(input logic rst, input logic [2:0] a, input logic cs,
                        input logic wn, input logic [31:0] wd);
        reset = rst; address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(posedge clk);
        model_update(rst, a, cs, wn, wd);
        #1;
        if (cs && !wn && !rst)
            $display("t=%0d write addr=%0d data=0x%08h out_port=0x%02h active=%0b",
                     t, a, wd, out_port, pulse_active);
        check("out_port", 32'(out_port), 32'(m_data));
        check("pulse_active", 32'(pulse_active), 32'(m_active));
        check("pulse_done", 32'(pulse_done), 32'(m_done));
        check("readdata", readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b0, a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, a, 1'b1, 1'b1, 32'd0);
    endtask

    initial begin
        int hi, dn, guard;
        logic [31:0] tl1, tl2;
        logic [2:0] ra;
        logic rcs, rwr, rrst;
        logic [31:0] rwd;

        // Reset state
        step(1'b1, 3'd0, 1'b0, 1'b1, 32'd0);
        step(1'b1, 3'd0, 1'b0, 1'b1, 32'd0);
        check("reset_out", 32'(out_port), 32'hA5);
        check("reset_rdata", readdata, 32'd0);
        rd(3'd1);
        rd(3'd2);
        check("reset_plen", readdata, 32'd1);
        rd(3'd7);
        check("reset_status", readdata, 32'd0);

        // DATA / OUTSET / OUTCLEAR with TS_LAST gap
        wr(3'd0, 32'h0000_00F0);
        rd(3'd3);
        tl1 = readdata;
        rd(3'd0); rd(3'd0); rd(3'd0);
        wr(3'd4, 32'h0F);
        rd(3'd3);
        tl2 = readdata;
        check("tslast_gap", (tl2 - tl1) & 32'h3FF, 32'd5);
        wr(3'd5, 32'h30);
        check("set_clear_out", 32'(out_port), 32'hCF);

        // 5-cycle pulse on bit 0, bit 1 static
        wr(3'd0, 32'h02);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'd5);
        wr(3'd4, 32'h01);
        hi = int'(out_port[0]); dn = 0;
        for (int i = 0; i < 12; i++) begin
            rd(3'd7);
            hi += int'(out_port[0]); dn += int'(pulse_done);
        end
        check("pulse5_len", 32'(hi), 32'd5);
        check("pulse5_done", 32'(dn), 32'd1);
        check("pulse5_bit1", 32'(out_port[1]), 32'd1);

        // Retrigger at cycle 6 of a 10-cycle pulse
        wr(3'd2, 32'd10);
        wr(3'd4, 32'h01);
        hi = int'(out_port[0]); dn = 0;
        for (int i = 0; i < 5; i++) begin
            rd(3'd0);
            hi += int'(out_port[0]); dn += int'(pulse_done);
        end
        wr(3'd4, 32'h00);
        hi += int'(out_port[0]); dn += int'(pulse_done);
        for (int i = 0; i < 20; i++) begin
            rd(3'd0);
            hi += int'(out_port[0]); dn += int'(pulse_done);
        end
        check("retrig_len", 32'(hi), 32'd16);
        check("retrig_done", 32'(dn), 32'd1);

        // PULSE_LEN written 0 reads back 1 and gives a 1-cycle pulse
        wr(3'd2, 32'd0);
        rd(3'd2);
        check("plen0_reads1", readdata, 32'd1);
        wr(3'd4, 32'h01);
        hi = int'(out_port[0]);
        for (int i = 0; i < 4; i++) begin
            rd(3'd0);
            hi += int'(out_port[0]);
        end
        check("plen0_len", 32'(hi), 32'd1);

        // Counter clear coinciding with wrap: no overflow
        wr(3'd6, 32'd0);
        guard = 0;
        while (m_ts != TS_MAX && guard < 1100) begin
            rd(3'd6);
            guard++;
        end
        if (guard >= 1100) begin
            checks++; errors++;
            $display("FAIL wrap_wait observed=%0d expected=%0d", guard, TS_MAX);
        end
        wr(3'd6, 32'd0);
        rd(3'd7);
        check("wrap_clr_noovf", 32'(readdata[1]), 32'd0);
        // Natural wrap sets sticky overflow, W1C clears it
        for (int i = 0; i < 1030; i++) rd(3'd7);
        check("ovf_set", 32'(readdata[1]), 32'd1);
        wr(3'd7, 32'h2);
        rd(3'd7);
        check("ovf_cleared", 32'(readdata[1]), 32'd0);

        // Reset at cycle 3 of an 8-cycle pulse
        wr(3'd2, 32'd8);
        wr(3'd4, 32'h01);
        rd(3'd0); rd(3'd0);
        step(1'b1, 3'd0, 1'b0, 1'b1, 32'd0);
        check("rst_mid_out", 32'(out_port), 32'hA5);
        check("rst_mid_active", 32'(pulse_active), 32'd0);
        dn = int'(pulse_done);
        for (int i = 0; i < 10; i++) begin
            rd(3'd7);
            dn += int'(pulse_done);
        end
        check("rst_mid_nodone", 32'(dn), 32'd0);

        // OUTCLEAR in the expiry cycle applies both masks
        wr(3'd1, 32'h03);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h13);
        rd(3'd0); rd(3'd0);
        wr(3'd5, 32'h10);
        check("clr_expiry_out", 32'(out_port), 32'h00);
        check("clr_expiry_done", 32'(pulse_done), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ra   = 3'($urandom_range(0, 7));
            rwr  = ($urandom_range(0, 2) == 0);
            rcs  = rwr ? 1'b1 : 1'($urandom_range(0, 1));
            rrst = ($urandom_range(0, 299) == 0);
            if (ra == 3'd2) rwd = 32'($urandom_range(0, 12));
            else if (ra == 3'd1) rwd = ($urandom_range(0, 1) == 0) ? 32'h01 : $urandom;
            else rwd = $urandom;
            step(rrst, ra, rcs, ~rwr, rwd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
